pwm_bank: RTL

Multi-channel PWM generator. It replaces the single fixed-period PWM that drives the AUX buffer. Each of NUM_CH channels has run-time programmable on/off periods, output polarity, and continuous or N-pulse one-shot mode. Outputs feed the iobuf dout inputs of the Bus Pirate IO pins. Configuration is written through a simple register-write strobe from the memory-controller decode.

---
 rtl/pwm_bank.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with shadowed on/off periods, invert and N-pulse one-shot mode.
// Define PWM_IRQ_EN to add the sticky one-shot-done status bits and the irq output.
module pwm_bank #(
    parameter int NUM_CH    = 5,
    parameter int CNT_WIDTH = 16,
    localparam int CH_AW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CH_AW-1:0]     wr_ch,
    input  logic [1:0]           wr_sel,
    input  logic [CNT_WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [NUM_CH-1:0]    busy
`ifdef PWM_IRQ_EN
    ,
    output logic                 irq
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

`ifdef PWM_IRQ_EN
    logic [NUM_CH-1:0] status;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t               st, st_n;
        logic [CNT_WIDTH-1:0] on_sh, off_sh, pc_sh;
        logic [CNT_WIDTH-1:0] on_a, off_a, cnt, rem;
        logic [CNT_WIDTH-1:0] on_a_n, off_a_n, cnt_n, rem_n;
        logic                 en, en_n, inv, oneshot;
        logic                 pwm_q, busy_q;
        logic                 hit, ctrl_wr, en_w, os_w;
        logic                 boundary, start;
`ifdef PWM_IRQ_EN
        logic                 done;
        logic                 stat;
`endif

        assign hit     = wr_en && (wr_ch == CH_AW'(g));
        assign ctrl_wr = hit && (wr_sel == 2'd2);
        assign en_w    = ctrl_wr ? wr_data[0] : en;
        assign os_w    = ctrl_wr ? wr_data[2] : oneshot;

        always_comb begin
            st_n     = st;
            cnt_n    = cnt;
            rem_n    = rem;
            on_a_n   = on_a;
            off_a_n  = off_a;
            en_n     = en_w;
            boundary = 1'b0;
            start    = 1'b0;
`ifdef PWM_IRQ_EN
            done     = 1'b0;
`endif
            case (st)
                ST_IDLE: begin
                    if (en_w) begin
                        if (os_w && (pc_sh == '0)) begin
                            en_n = 1'b0;
                        end else begin
                            rem_n = pc_sh;
                            start = 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    if (cnt == '0) begin
                        if (off_a != '0) begin
                            st_n  = ST_OFF;
                            cnt_n = off_a - ONE;
                        end else begin
                            boundary = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                ST_OFF: begin
                    if (cnt == '0) boundary = 1'b1;
                    else           cnt_n = cnt - ONE;
                end
                default: st_n = ST_IDLE;
            endcase

            // End of a full period: one-shot trains count down, continuous ones just reload.
            if (boundary) begin
                if (os_w) begin
                    if (rem <= ONE) begin
                        st_n = ST_IDLE;
                        en_n = 1'b0;
`ifdef PWM_IRQ_EN
                        done = 1'b1;
`endif
                    end else begin
                        rem_n = rem - ONE;
                        start = 1'b1;
                    end
                end else begin
                    start = 1'b1;
                end
            end

            // A zero-length phase is skipped in the same cycle; both zero parks in IDLE.
            if (start) begin
                on_a_n  = on_sh;
                off_a_n = off_sh;
                if (on_sh != '0) begin
                    st_n  = ST_ON;
                    cnt_n = on_sh - ONE;
                end else if (off_sh != '0) begin
                    st_n  = ST_OFF;
                    cnt_n = off_sh - ONE;
                end else begin
                    st_n = ST_IDLE;
                end
            end

            if (ctrl_wr && !wr_data[0]) st_n = ST_IDLE;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                st      <= ST_IDLE;
                cnt     <= '0;
                rem     <= '0;
                on_a    <= '0;
                off_a   <= '0;
                on_sh   <= '0;
                off_sh  <= '0;
                pc_sh   <= '0;
                en      <= 1'b0;
                inv     <= 1'b0;
                oneshot <= 1'b0;
                pwm_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                st      <= st_n;
                cnt     <= cnt_n;
                rem     <= rem_n;
                on_a    <= on_a_n;
                off_a   <= off_a_n;
                en      <= en_n;
                pwm_q   <= (st == ST_ON) ? ~inv : inv;
                busy_q  <= (st != ST_IDLE);
                if (hit) begin
                    case (wr_sel)
                        2'd0: on_sh  <= wr_data;
                        2'd1: off_sh <= wr_data;
                        2'd2: begin
                            inv     <= wr_data[1];
                            oneshot <= wr_data[2];
                        end
                        default: pc_sh <= wr_data;
                    endcase
                end
            end
        end

        assign pwm_out[g] = pwm_q;
        assign busy[g]    = busy_q;

`ifdef PWM_IRQ_EN
        // Completion beats a clear landing on the same edge.
        always_ff @(posedge clock) begin
            if (reset)                         stat <= 1'b0;
            else if (done)                     stat <= 1'b1;
            else if (ctrl_wr && wr_data[3])    stat <= 1'b0;
        end
        assign status[g] = stat;
`endif
    end

`ifdef PWM_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset) irq <= 1'b0;
        else       irq <= |status;
    end
`endif

endmodule
